// File: rtl/life_pkg.sv
// Shared types, constants and the cell update rule for the Life field stepper.
package life_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_SWAP  = 2'd2
   } life_state_t;

   localparam int NBRS_CNT = 8;

   // Conway B3/S23
   localparam logic [NBRS_CNT:0] B3_MASK  = 9'b0_0000_1000;
   localparam logic [NBRS_CNT:0] S23_MASK = 9'b0_0000_1100;

   function automatic logic life_next_state(input logic alive,
                                            input logic [3:0] n,
                                            input logic [NBRS_CNT:0] birth,
                                            input logic [NBRS_CNT:0] survive);
      logic nxt;
      if (n > 4'(NBRS_CNT))
         nxt = 1'b0;
      else
         nxt = alive ? survive[n] : birth[n];
      return nxt;
   endfunction

endpackage

// File: rtl/life_nbr_count.sv
// Live-neighbour count of one cell over the 3x3 window around the scan position.
// LIFE_FIELD_WRAP_EN selects a toroidal field; otherwise off-field neighbours are dead.
module life_nbr_count
   import life_pkg::*;
#(
   parameter int FIELD_W    = 32,
   parameter int FIELD_H    = 32,
   parameter int X_ADR_SIZE = $clog2(FIELD_W),
   parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
   input  logic [X_ADR_SIZE-1:0]      scan_x,
   input  logic [Y_ADR_SIZE-1:0]      scan_y,
   input  logic [FIELD_W*FIELD_H-1:0] field,
   output logic [3:0]                 nbr_cnt
);

   localparam int CELLS = FIELD_W * FIELD_H;
   localparam int IDX_W = $clog2(CELLS);

   int   nx;
   int   ny;
   logic hit;

   // Window position k = 0..8 maps to dx = k%3-1, dy = k/3-1; k = 4 is the cell itself.
   always_comb begin
      nbr_cnt = '0;
      nx      = 0;
      ny      = 0;
      hit     = 1'b0;
      for (int k = 0; k <= NBRS_CNT; k++) begin
         nx = int'(scan_x) + (k % 3) - 1;
         ny = int'(scan_y) + (k / 3) - 1;
`ifdef LIFE_FIELD_WRAP_EN
         if (nx < 0)             nx = nx + FIELD_W;
         else if (nx >= FIELD_W) nx = nx - FIELD_W;
         if (ny < 0)             ny = ny + FIELD_H;
         else if (ny >= FIELD_H) ny = ny - FIELD_H;
         hit = (k != NBRS_CNT / 2);
`else
         hit = (k != NBRS_CNT / 2) && (nx >= 0) && (nx < FIELD_W) &&
               (ny >= 0) && (ny < FIELD_H);
`endif
         if (hit)
            nbr_cnt = nbr_cnt + 4'(field[IDX_W'(ny * FIELD_W + nx)]);
      end
   end

endmodule

// File: rtl/life_field_stepper.sv
// Double-buffered Life field: host edits/reads the front buffer, i_step sweeps one generation
// into the back buffer and swaps. Build option: LIFE_FIELD_WRAP_EN (toroidal field).
module life_field_stepper
   import life_pkg::*;
#(
   parameter int         FIELD_W      = 32,
   parameter int         FIELD_H      = 32,
   parameter logic [8:0] BIRTH_MASK   = B3_MASK,
   parameter logic [8:0] SURVIVE_MASK = S23_MASK,
   parameter int         GEN_W        = 16,
   parameter int         X_ADR_SIZE   = $clog2(FIELD_W),
   parameter int         Y_ADR_SIZE   = $clog2(FIELD_H),
   parameter int         POP_W        = $clog2(FIELD_W * FIELD_H + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [X_ADR_SIZE-1:0] i_cell_x_adr,
   input  logic [Y_ADR_SIZE-1:0] i_cell_y_adr,
   input  logic                  i_w_en,
   input  logic                  i_new_cell_state,
   output logic                  o_cell_state,
   input  logic                  i_step,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [GEN_W-1:0]      o_gen_cnt,
   output logic [POP_W-1:0]      o_alive_cnt
);

   localparam int CELLS = FIELD_W * FIELD_H;
   localparam int IDX_W = $clog2(CELLS);

   life_state_t           state, state_nxt;
   logic                  sel;
   logic [CELLS-1:0]      buf0, buf1, front;
   logic [X_ADR_SIZE-1:0] sx;
   logic [Y_ADR_SIZE-1:0] sy;
   logic [POP_W-1:0]      acc;
   logic [3:0]            nbr_cnt;
   logic                  cell_nxt;
   logic                  scan_last;
   logic                  host_in;
   logic [IDX_W-1:0]      host_idx;
   logic [IDX_W-1:0]      scan_idx;

   assign front     = sel ? buf1 : buf0;
   assign host_in   = (int'(i_cell_x_adr) < FIELD_W) && (int'(i_cell_y_adr) < FIELD_H);
   assign host_idx  = IDX_W'(int'(i_cell_y_adr) * FIELD_W + int'(i_cell_x_adr));
   assign scan_idx  = IDX_W'(int'(sy) * FIELD_W + int'(sx));
   assign scan_last = (int'(sx) == FIELD_W - 1) && (int'(sy) == FIELD_H - 1);

   // Off-field addresses read dead rather than aliasing onto another cell.
   assign o_cell_state = host_in & front[host_idx];

   life_nbr_count #(
      .FIELD_W    (FIELD_W),
      .FIELD_H    (FIELD_H),
      .X_ADR_SIZE (X_ADR_SIZE),
      .Y_ADR_SIZE (Y_ADR_SIZE)
   ) u_nbr (
      .scan_x  (sx),
      .scan_y  (sy),
      .field   (front),
      .nbr_cnt (nbr_cnt)
   );

   assign cell_nxt = life_next_state(front[scan_idx], nbr_cnt, BIRTH_MASK, SURVIVE_MASK);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (i_step)    state_nxt = ST_SWEEP;
         ST_SWEEP: if (scan_last) state_nxt = ST_SWAP;
         ST_SWAP:                 state_nxt = ST_IDLE;
         default:                 state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf0        <= '0;
         buf1        <= '0;
         sel         <= 1'b0;
         sx          <= '0;
         sy          <= '0;
         acc         <= '0;
         o_done      <= 1'b0;
         o_gen_cnt   <= '0;
         o_alive_cnt <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A write coinciding with i_step lands first, so the sweep sees it.
               if (i_w_en && host_in) begin
                  if (sel) buf1[host_idx] <= i_new_cell_state;
                  else     buf0[host_idx] <= i_new_cell_state;
               end
               if (i_step) begin
                  sx  <= '0;
                  sy  <= '0;
                  acc <= '0;
               end
            end
            ST_SWEEP: begin
               if (sel) buf0[scan_idx] <= cell_nxt;
               else     buf1[scan_idx] <= cell_nxt;
               acc <= acc + POP_W'(cell_nxt);
               if (int'(sx) == FIELD_W - 1) begin
                  sx <= '0;
                  sy <= sy + 1'b1;
               end else begin
                  sx <= sx + 1'b1;
               end
               o_done <= scan_last;
            end
            ST_SWAP: begin
               sel         <= ~sel;
               o_gen_cnt   <= o_gen_cnt + 1'b1;
               o_alive_cnt <= acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_life_field_stepper.sv
// Self-checking bench for life_field_stepper on an 8x8 field with a 2-bit generation counter.
module tb_life_field_stepper;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int GW = 2;
   localparam int PW = 7;
   localparam logic [8:0] BM = 9'b0_0000_1000;
   localparam logic [8:0] SM = 9'b0_0000_1100;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [2:0]    x_adr = '0;
   logic [2:0]    y_adr = '0;
   logic          w_en = 1'b0;
   logic          new_state = 1'b0;
   logic          cell_state;
   logic          step = 1'b0;
   logic          busy;
   logic          done;
   logic [GW-1:0] gen;
   logic [PW-1:0] alive;

   always #5 clk = ~clk;

   life_field_stepper #(
      .FIELD_W (W),
      .FIELD_H (H),
      .GEN_W   (GW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_cell_x_adr     (x_adr),
      .i_cell_y_adr     (y_adr),
      .i_w_en           (w_en),
      .i_new_cell_state (new_state),
      .o_cell_state     (cell_state),
      .i_step           (step),
      .o_busy           (busy),
      .o_done           (done),
      .o_gen_cnt        (gen),
      .o_alive_cnt      (alive)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Reference generation: field bit index is y*W + x.
   function automatic logic [63:0] ref_step(input logic [63:0] f);
      logic [63:0] r;
      logic [8:0]  bm;
      logic [8:0]  sm;
      r  = '0;
      bm = BM;
      sm = SM;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            int n;
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  int xx;
                  int yy;
                  if (dx == 0 && dy == 0) continue;
                  xx = x + dx;
                  yy = y + dy;
`ifdef LIFE_FIELD_WRAP_EN
                  xx = (xx + W) % W;
                  yy = (yy + H) % H;
`else
                  if (xx < 0 || xx >= W || yy < 0 || yy >= H) continue;
`endif
                  n += int'(f[yy * W + xx]);
               end
            end
            r[y * W + x] = f[y * W + x] ? sm[n] : bm[n];
         end
      end
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic wr(input int x, input int y, input logic v);
      @(negedge clk);
      x_adr     = 3'(x);
      y_adr     = 3'(y);
      new_state = v;
      w_en      = 1'b1;
      @(negedge clk) w_en = 1'b0;
   endtask

   task automatic load(input logic [63:0] f);
      for (int i = 0; i < W * H; i++) wr(i % W, i / W, f[i]);
   endtask

   task automatic read_field(output logic [63:0] f);
      f = '0;
      @(negedge clk);
      for (int i = 0; i < W * H; i++) begin
         x_adr = 3'(i % W);
         y_adr = 3'(i / W);
         #1 f[i] = cell_state;
      end
   endtask

   // One step: o_done must appear in the SWAP cycle (64 edges after the step edge)
   // exactly once, and busy must drop one edge later.
   task automatic do_step();
      int lat;
      int pulses;
      int exit_j;
      lat    = -1;
      pulses = 0;
      exit_j = -1;
      @(negedge clk) step = 1'b1;
      @(posedge clk);
      #1 step = 1'b0;
      chk("step_busy_rise", busy, 1);
      for (int j = 1; j < 200; j++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            if (lat < 0) lat = j;
         end
         if (!busy) begin
            exit_j = j;
            break;
         end
      end
      chk("step_done_latency", lat, W * H);
      chk("step_done_pulses", pulses, 1);
      chk("step_busy_fall", exit_j, W * H + 1);
   endtask

   typedef struct {
      string       name;
      logic [63:0] init;
      int          steps;
      logic [63:0] exp_f;
      int          exp_alive;
   } vec_t;

   vec_t vecs[3];

   initial begin
      logic [63:0] f;
      logic [63:0] m;
      logic        found;

      vecs[0] = '{"blinker", (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35), 1,
                  (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28), 3};
      vecs[1] = '{"block", (64'd1 << 45) | (64'd1 << 46) | (64'd1 << 53) | (64'd1 << 54), 3,
                  (64'd1 << 45) | (64'd1 << 46) | (64'd1 << 53) | (64'd1 << 54), 4};
`ifdef LIFE_FIELD_WRAP_EN
      vecs[2] = '{"corners", (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56), 1,
                  (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56) | (64'd1 << 63), 4};
`else
      vecs[2] = '{"corners", (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56), 1, 64'd0, 0};
`endif

      // Reset state
      do_reset();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_gen", gen, 0);
      chk("rst_alive", alive, 0);
      read_field(f);
      chk("rst_field", f, 0);

      // Table-driven patterns
      for (int i = 0; i < 3; i++) begin
         do_reset();
         load(vecs[i].init);
         m = vecs[i].init;
         for (int s = 0; s < vecs[i].steps; s++) begin
            do_step();
            m = ref_step(m);
         end
         read_field(f);
         chk({vecs[i].name, "_field"}, f, vecs[i].exp_f);
         chk({vecs[i].name, "_model"}, f, m);
         chk({vecs[i].name, "_alive"}, alive, vecs[i].exp_alive);
         chk({vecs[i].name, "_gen"}, gen, vecs[i].steps % 4);
      end

      // Host write and step while busy are ignored; old generation visible until swap
      do_reset();
      load(vecs[0].init);
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      repeat (9) @(negedge clk);
      x_adr = 3'd1; y_adr = 3'd1; new_state = 1'b1; w_en = 1'b1; step = 1'b1;
      @(negedge clk);
      w_en = 1'b0; step = 1'b0;
      x_adr = 3'd3; y_adr = 3'd3;
      #1 chk("busy_mid_33", cell_state, 1);
      x_adr = 3'd3; y_adr = 3'd2;
      #1 chk("busy_mid_32", cell_state, 1);
      found = 1'b0;
      for (int j = 0; j < 200; j++) begin
         @(negedge clk);
         if (done) begin
            found = 1'b1;
            break;
         end
      end
      chk("busy_done_seen", found, 1);
      chk("busy_swap_old_32", cell_state, 1);
      @(negedge clk);
      chk("busy_new_32", cell_state, 0);
      chk("busy_idle_after", busy, 0);
      @(negedge clk);
      chk("busy_stray_step", busy, 0);
      read_field(f);
      chk("busy_field", f, vecs[0].exp_f);
      chk("busy_gen", gen, 1);

      // Reset during sweep cycle 30 after one completed generation
      do_reset();
      load(vecs[0].init);
      do_step();
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      repeat (29) @(negedge clk);
      chk("abort_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_gen", gen, 0);
      chk("abort_alive", alive, 0);
      chk("abort_done", done, 0);
      read_field(f);
      chk("abort_field", f, 0);

      // 2-bit generation counter wraps on an empty field
      do_reset();
      for (int s = 0; s < 4; s++) begin
         do_step();
         chk("wrap_gen", gen, (s + 1) % 4);
         chk("wrap_alive", alive, 0);
      end

      // Random fields against the reference model
      for (int r = 0; r < 6; r++) begin
         do_reset();
         f = {$urandom, $urandom};
         if (r % 2 == 1) f = f & {$urandom, $urandom};
         load(f);
         m = f;
         read_field(f);
         chk("rand_load", f, m);
         for (int s = 0; s < 3; s++) begin
            do_step();
            m = ref_step(m);
            read_field(f);
            chk("rand_field", f, m);
            chk("rand_alive", alive, $countones(m));
            chk("rand_gen", gen, (s + 1) % 4);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/life_field_stepper.md
# life_field_stepper

Double-buffered Game of Life field store with a built-in generation engine. Host logic (the editor/cursor and the VGA scan-out) reads and writes cells of the front buffer. On an `i_step` request, an internal FSM sweeps every cell in raster order, computes its next state under a parametrised birth/survive rule, writes it into the back buffer, then swaps buffers. It sits between the control/UI logic and the display path, and replaces the single-buffer field store that had no stepping logic of its own.

## Interface
- `FIELD_W`, 32: field width in cells; must be ≥ 3.
- `FIELD_H`, 32: field height in cells; must be ≥ 3.
- `BIRTH_MASK`, 9'b0_0000_1000: bit n set means a dead cell with n live neighbours is born.
- `SURVIVE_MASK`, 9'b0_0000_1100: bit n set means a live cell with n live neighbours survives.
- `GEN_W`, 16: width of the generation counter.
- Derived: `X_ADR_SIZE` = $clog2(FIELD_W), `Y_ADR_SIZE` = $clog2(FIELD_H), `POP_W` = $clog2(FIELD_W*FIELD_H+1).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `i_cell_x_adr`  in  X_ADR_SIZE  host cell column.
- `i_cell_y_adr`  in  Y_ADR_SIZE  host cell row.
- `i_w_en`  in  1  host write strobe into the front buffer.
- `i_new_cell_state`  in  1  value written on `i_w_en`.
- `o_cell_state`  out  1  combinational read of the front buffer at the host address.
- `i_step`  in  1  request to compute one generation.
- `o_busy`  out  1  high while the sweep or swap is in progress.
- `o_done`  out  1  one-cycle pulse when the new generation becomes the front buffer.
- `o_gen_cnt`  out  GEN_W  number of completed generations, modulo 2^GEN_W.
- `o_alive_cnt`  out  POP_W  population of the current front buffer after the last step.

## Operation
- FSM states: IDLE, SWEEP, SWAP.
- IDLE:
  - `i_w_en` writes the front buffer.
  - `i_step` moves the FSM to SWEEP, with the scan position at (0,0) and the population accumulator at 0.
- SWEEP, one cell per cycle, x fastest:
  - n = number of live neighbours in the front buffer (0..8, 4 bits).
  - next = alive ? SURVIVE_MASK[n] : BIRTH_MASK[n]; next is written to the back buffer at the scan position.
  - The accumulator adds next.
  - At (FIELD_W-1, FIELD_H-1), the FSM moves to SWAP.
- SWAP, one cycle:
  - Toggle the buffer select.
  - `o_gen_cnt` increments, wrapping to 0.
  - `o_alive_cnt` takes the accumulator value.
  - `o_done` = 1, then the FSM returns to IDLE.
- Busy behaviour: `i_w_en` and `i_step` are ignored while `o_busy` is high. `o_cell_state` keeps returning the old generation until the swap.
- Simultaneous `i_w_en` and `i_step` in IDLE: the write commits at that edge, and the sweep sees the written value.
- Host writes do not update `o_alive_cnt`. It reflects only the last step.
- Addresses ≥ FIELD_W or ≥ FIELD_H: writes are dropped and `o_cell_state` reads 0.

## Timing
- Reset values:
  - Both buffers are all-dead and the select is 0.
  - The FSM is in IDLE.
  - `o_busy`, `o_done`, `o_gen_cnt` and `o_alive_cnt` are all 0.
- Reset mid-sweep aborts immediately with the same values; no partial generation becomes visible.
- Timeline when `i_step` is sampled at edge k:
  - `o_busy` is high from cycle k+1 through cycle k+W·H+1.
  - The SWEEP cycles are k+1 .. k+W·H.
  - The SWAP cycle is k+W·H+1, and `o_done` is high in that cycle.
  - In cycle k+W·H+2, `o_cell_state` shows the new generation and a new `i_step` is accepted.
- `o_done`, `o_gen_cnt` and `o_alive_cnt` are registered outputs. `o_cell_state` is combinational from the address inputs.

## Configuration
- `LIFE_FIELD_WRAP_EN` defined: the field is toroidal. Neighbour x is taken modulo FIELD_W and neighbour y modulo FIELD_H.
- `LIFE_FIELD_WRAP_EN` undefined: neighbours outside the field count as dead (bounded plane).

## Structure
- Package `life_pkg` holds:
  - the FSM state enum;
  - `NBRS_CNT` = 8;
  - the default B3/S23 masks;
  - a `life_next_state(alive, n, birth, survive)` function.
- Sub-module `life_nbr_count`: combinational. It takes the scan x/y and the front buffer, forms the 8 neighbour addresses with edge or wrap handling, and returns the 4-bit count.
- The top level holds the two buffers, the FSM, the scan counters, the accumulator and the generation counter.

## Test plan
- 8×8 field, blinker at (3,2),(3,3),(3,4), step:
  - `o_done` is seen exactly 65 cycles after the `i_step` edge.
  - The live cells become (2,3),(3,3),(4,3).
  - `o_alive_cnt` = 3 and `o_gen_cnt` = 1.
- 2×2 block at (5,5):
  - After 3 steps the field is unchanged.
  - `o_alive_cnt` = 4 and `o_gen_cnt` = 3.
- Live cells (0,0),(7,0),(0,7) on 8×8:
  - With `LIFE_FIELD_WRAP_EN`, (7,7) is born after one step.
  - Without it, the field after one step is all dead and `o_alive_cnt` = 0.
- Pulse `i_step` and `i_w_en` to (1,1) during busy:
  - Neither has any effect.
  - `o_cell_state` at (3,3) stays at the old value until the swap.
- Assert `rst` at sweep cycle 30:
  - The next cycle shows `o_busy` = 0, `o_gen_cnt` = 0, and every cell reading 0.
- `GEN_W` = 2, four steps on an empty field:
  - `o_gen_cnt` reads 1,2,3,0.
  - `o_done` pulses exactly once per step.
